mips_run_ctrl: RTL and testbench
================================

Name: mips_run_ctrl

Overview:
- Synthesizable run controller and trace capture unit for the single-cycle MIPS core.
- Gates the core's clock enable under command control: run, step N cycles, halt, or stop on a PC breakpoint.
- Records (pc, alu_result) for each executed cycle into a circular trace buffer, which can be read back while halted.
- Replaces open-coded clock toggling in benches; can also be placed on-chip for bring-up.

Parameters:
- DATA_W, 32, width of the pc and alu_result taps.
- TRACE_DEPTH, 16, trace entries; must be a power of 2 and at least 2.
- CNT_W, 16, width of the step count.
- NUM_BP, 2, number of PC breakpoint comparators.

Ports:
- clk  in  1  system clock; every register is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command strobe.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_op  in  2  0=HALT, 1=RUN, 2=STEP, 3=CLEAR.
- cmd_count  in  CNT_W  step count; sampled only when a STEP is accepted.
- bp_en  in  NUM_BP  per-comparator enable.
- bp_addr  in  NUM_BP*DATA_W  breakpoint PCs; comparator i uses slice i.
- pc_in  in  DATA_W  core pc_out.
- alu_in  in  DATA_W  core alu_result.
- core_en  out  1  core clock enable.
- run_state  out  2  0=IDLE, 1=RUN, 2=STEP, 3=HALTED.
- halt_reason  out  2  0=NONE, 1=CMD, 2=BP, 3=STEP_DONE.
- cmd_err  out  1  one-cycle pulse when an accepted command is illegal in the current state.
- cycle_count  out  DATA_W  number of executed cycles; wraps modulo 2^DATA_W.
- trace_rd_en  in  1  pop the oldest trace entry.
- trace_rd_valid  out  1  trace_rd_data is valid.
- trace_rd_data  out  2*DATA_W  {pc, alu}.
- trace_count  out  log2(TRACE_DEPTH)+1  number of stored entries.
- trace_wrapped  out  1  set when an entry has been overwritten since the last CLEAR.

Behaviour:
- Reset (asynchronous): run_state=IDLE, core_en=0, halt_reason=NONE, cycle_count=0, trace empty, trace_wrapped=0, trace_rd_valid=0, cmd_err=0. A reset mid-run drops core_en in the same instant.
- cmd_ready is tied to 1.
- IDLE/HALTED:
  - RUN goes to RUN.
  - STEP goes to STEP and loads the remaining count with cmd_count; a count of 0 is treated as 1.
  - CLEAR empties the trace, zeroes cycle_count and trace_wrapped, and sets halt_reason=NONE.
  - HALT is a no-op.
- RUN/STEP:
  - HALT goes to HALTED with reason CMD.
  - RUN, STEP and CLEAR are ignored and pulse cmd_err the next cycle.
- core_en = (run_state is RUN or STEP). It is registered, so it rises one cycle after the command is accepted.
- Executed cycle = any cycle with core_en=1. Each executed cycle:
  - writes {pc_in, alu_in} at the write pointer;
  - increments cycle_count;
  - in STEP, decrements the remaining count.
- Breakpoint: a hit is core_en & bp_en[i] & (pc_in == bp_addr[i]) for any i. The matching cycle still executes and is traced, and the next state is HALTED with reason BP.
- Step done: the executed cycle that brings the remaining count to 0 leads to HALTED with reason STEP_DONE. Exactly N cycles execute.
- Simultaneous terminating events in one cycle: priority is CMD > BP > STEP_DONE. Only one transition and one reason are recorded.
- Trace buffer:
  - Circular; trace_count saturates at TRACE_DEPTH.
  - When full, a write overwrites the oldest entry, advances the read pointer, and sets trace_wrapped.
- Trace readout:
  - trace_rd_en is honoured only in IDLE/HALTED and only when trace_count>0.
  - Data appears the next cycle with trace_rd_valid=1 for one cycle, and trace_count decrements.
  - Reads while running or while empty are ignored: trace_rd_valid stays 0 and there is no error.
- Pointers wrap modulo TRACE_DEPTH.
- Breakpoint compare uses the raw pc_in; no alignment masking.

Decomposition:
- Shared package mips_dbg_pkg holds:
  - cmd_op codes;
  - run_state and halt_reason encodings;
  - the trace entry width function 2*DATA_W.
- One natural sub-module, mips_trace_buf: parametrised circular buffer with push/pop, count, overwrite-on-full and a wrapped flag.
- The FSM, breakpoint comparators and counters stay in mips_run_ctrl.

Test Plan:
- Reset then STEP with cmd_count=5, core pc incrementing by 4 from 0 -> core_en high for exactly 5 cycles; HALTED with reason STEP_DONE; cycle_count=5; trace_count=5; readout gives pc 0,4,8,12,16 in order.
- RUN with bp_en=01 and bp_addr[0]=0x20, pc stepping by 4 from 0 -> 9 executed cycles, the last with pc=0x20 traced; HALTED with reason BP.
- RUN for 20 cycles then HALT, TRACE_DEPTH=16 -> trace_count=16; trace_wrapped=1; first read returns the 5th executed entry (index 4).
- HALT command in the same cycle as a breakpoint hit and the final step -> halt_reason=CMD.
- RUN accepted while already in RUN -> cmd_err pulses once; state stays RUN. STEP with cmd_count=0 -> exactly 1 cycle executes.
- Reset asserted during RUN -> core_en=0 immediately; all outputs return to reset values; trace_rd_en after reset gives no valid data.

Source files
------------

// File: rtl/mips_dbg_pkg.sv
// Shared encodings for the MIPS run controller: command opcodes, run states,
// halt reasons and the trace entry width helper.
package mips_dbg_pkg;

    localparam logic [1:0] OP_HALT  = 2'd0;
    localparam logic [1:0] OP_RUN   = 2'd1;
    localparam logic [1:0] OP_STEP  = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_STEP   = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    localparam logic [1:0] RSN_NONE      = 2'd0;
    localparam logic [1:0] RSN_CMD       = 2'd1;
    localparam logic [1:0] RSN_BP        = 2'd2;
    localparam logic [1:0] RSN_STEP_DONE = 2'd3;

    function automatic int trace_entry_w(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/mips_trace_buf.sv
// Circular trace buffer: push overwrites the oldest entry when full, pop
// returns the oldest entry one cycle later with a single-cycle valid.
module mips_trace_buf
    import mips_dbg_pkg::*;
#(
    parameter int ENTRY_W = 64,
    parameter int DEPTH   = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_push_data,
    input  logic               i_pop,
    output logic               o_rd_valid,
    output logic [ENTRY_W-1:0] o_rd_data,
    output logic [AW:0]        o_count,
    output logic               o_wrapped
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ZERO_CNT = (AW + 1)'(0);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic               r_wrapped;
    logic               r_rd_valid;
    logic [ENTRY_W-1:0] r_rd_data;
    logic               w_full;
    logic               w_pop_ok;

    assign w_full   = (r_count == FULL_CNT);
    assign w_pop_ok = i_pop && (r_count != ZERO_CNT);

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers, occupancy, wrap flag and registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wrapped  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else if (i_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wrapped  <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop_ok;
            if (w_pop_ok) begin
                r_rd_data <= r_mem[r_rd_ptr];
            end
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            // A full push drops the oldest entry, so the read side moves too.
            if (w_pop_ok || (i_push && w_full)) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({i_push, w_pop_ok})
                2'b10:   r_count <= w_full ? r_count : r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (i_push && w_full && !w_pop_ok) begin
                r_wrapped <= 1'b1;
            end
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;
    assign o_count    = r_count;
    assign o_wrapped  = r_wrapped;

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for the single-cycle MIPS core: gates core_en for RUN/STEP,
// halts on command, breakpoint or step exhaustion, and traces executed cycles.
module mips_run_ctrl
    import mips_dbg_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TRACE_DEPTH = 16,
    parameter int CNT_W       = 16,
    parameter int NUM_BP      = 2,
    localparam int TCW        = $clog2(TRACE_DEPTH) + 1,
    localparam int EW         = trace_entry_w(DATA_W)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [CNT_W-1:0]         cmd_count,
    input  logic [NUM_BP-1:0]        bp_en,
    input  logic [NUM_BP*DATA_W-1:0] bp_addr,
    input  logic [DATA_W-1:0]        pc_in,
    input  logic [DATA_W-1:0]        alu_in,
    output logic                     core_en,
    output logic [1:0]               run_state,
    output logic [1:0]               halt_reason,
    output logic                     cmd_err,
    output logic [DATA_W-1:0]        cycle_count,
    input  logic                     trace_rd_en,
    output logic                     trace_rd_valid,
    output logic [EW-1:0]            trace_rd_data,
    output logic [TCW-1:0]           trace_count,
    output logic                     trace_wrapped
);

    logic [1:0]        r_state;
    logic              r_core_en;
    logic [1:0]        r_reason;
    logic              r_err;
    logic [DATA_W-1:0] r_cycles;
    logic [CNT_W-1:0]  r_rem;

    logic [1:0]        w_state_n;
    logic [1:0]        w_reason_n;
    logic [CNT_W-1:0]  w_rem_n;
    logic              w_err_n;
    logic              w_clear;
    logic              w_bp_hit;
    logic              w_halt_cmd;

    assign cmd_ready  = 1'b1;
    assign w_halt_cmd = cmd_valid && (cmd_op == OP_HALT);

    // Breakpoint comparators on the raw PC; only live while the core executes.
    always_comb begin
        w_bp_hit = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_en[i] && (pc_in == bp_addr[i*DATA_W +: DATA_W])) begin
                w_bp_hit = r_core_en;
            end else begin
                w_bp_hit = w_bp_hit;
            end
        end
    end

    // Next-state decode; terminating events ranked CMD > BP > STEP_DONE.
    always_comb begin
        w_state_n  = r_state;
        w_reason_n = r_reason;
        w_rem_n    = r_rem;
        w_err_n    = 1'b0;
        w_clear    = 1'b0;
        if (r_core_en) begin
            w_rem_n = (r_state == ST_STEP) ? r_rem - CNT_W'(1) : r_rem;
            w_err_n = cmd_valid && !w_halt_cmd;
            if (w_halt_cmd) begin
                w_state_n  = ST_HALTED;
                w_reason_n = RSN_CMD;
            end else if (w_bp_hit) begin
                w_state_n  = ST_HALTED;
                w_reason_n = RSN_BP;
            end else if ((r_state == ST_STEP) && (r_rem == CNT_W'(1))) begin
                w_state_n  = ST_HALTED;
                w_reason_n = RSN_STEP_DONE;
            end else begin
                w_state_n  = r_state;
            end
        end else if (cmd_valid) begin
            case (cmd_op)
                OP_RUN: begin
                    w_state_n = ST_RUN;
                end
                OP_STEP: begin
                    w_state_n = ST_STEP;
                    w_rem_n   = (cmd_count == '0) ? CNT_W'(1) : cmd_count;
                end
                OP_CLEAR: begin
                    w_clear    = 1'b1;
                    w_reason_n = RSN_NONE;
                end
                default: begin
                    w_state_n = r_state;
                end
            endcase
        end else begin
            w_state_n = r_state;
        end
    end

    // Control registers; core_en tracks the next state so it is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_core_en <= 1'b0;
            r_reason  <= RSN_NONE;
            r_err     <= 1'b0;
            r_rem     <= '0;
            r_cycles  <= '0;
        end else begin
            r_state   <= w_state_n;
            r_core_en <= (w_state_n == ST_RUN) || (w_state_n == ST_STEP);
            r_reason  <= w_reason_n;
            r_err     <= w_err_n;
            r_rem     <= w_rem_n;
            if (w_clear) begin
                r_cycles <= '0;
            end else if (r_core_en) begin
                r_cycles <= r_cycles + DATA_W'(1);
            end else begin
                r_cycles <= r_cycles;
            end
        end
    end

    mips_trace_buf #(
        .ENTRY_W (EW),
        .DEPTH   (TRACE_DEPTH)
    ) u_trace (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_clear),
        .i_push      (r_core_en),
        .i_push_data ({pc_in, alu_in}),
        .i_pop       (trace_rd_en && !r_core_en),
        .o_rd_valid  (trace_rd_valid),
        .o_rd_data   (trace_rd_data),
        .o_count     (trace_count),
        .o_wrapped   (trace_wrapped)
    );

    assign core_en     = r_core_en;
    assign run_state   = r_state;
    assign halt_reason = r_reason;
    assign cmd_err     = r_err;
    assign cycle_count = r_cycles;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Self-checking bench for mips_run_ctrl: directed scenarios plus random
// command traffic, compared each cycle against a queue-based reference model.
module tb_mips_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_count;
    logic [1:0]  bp_en;
    logic [63:0] bp_addr;
    logic [31:0] pc_in;
    logic [31:0] alu_in;
    logic        core_en;
    logic [1:0]  run_state;
    logic [1:0]  halt_reason;
    logic        cmd_err;
    logic [31:0] cycle_count;
    logic        trace_rd_en;
    logic        trace_rd_valid;
    logic [63:0] trace_rd_data;
    logic [4:0]  trace_count;
    logic        trace_wrapped;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: plain counters and a queue of traced entries.
    int          m_state;
    int          m_reason;
    int          m_rem;
    logic [31:0] m_cycles;
    logic [63:0] m_q[$];
    bit          m_wrapped;
    bit          m_err;
    bit          m_rdv;
    logic [63:0] m_rdd;
    logic [31:0] bpc;

    always #5 clk = ~clk;

    mips_run_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_count      (cmd_count),
        .bp_en          (bp_en),
        .bp_addr        (bp_addr),
        .pc_in          (pc_in),
        .alu_in         (alu_in),
        .core_en        (core_en),
        .run_state      (run_state),
        .halt_reason    (halt_reason),
        .cmd_err        (cmd_err),
        .cycle_count    (cycle_count),
        .trace_rd_en    (trace_rd_en),
        .trace_rd_valid (trace_rd_valid),
        .trace_rd_data  (trace_rd_data),
        .trace_count    (trace_count),
        .trace_wrapped  (trace_wrapped)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state   = 0;
        m_reason  = 0;
        m_rem     = 0;
        m_cycles  = 32'd0;
        m_q.delete();
        m_wrapped = 1'b0;
        m_err     = 1'b0;
        m_rdv     = 1'b0;
        m_rdd     = 64'd0;
        bpc       = 32'd0;
    endtask

    task automatic check_all();
        chk("cmd_ready", 64'(cmd_ready), 64'd1);
        chk("run_state", 64'(run_state), 64'(m_state));
        chk("core_en", 64'(core_en), 64'((m_state == 1) || (m_state == 2)));
        chk("halt_reason", 64'(halt_reason), 64'(m_reason));
        chk("cmd_err", 64'(cmd_err), 64'(m_err));
        chk("cycle_count", 64'(cycle_count), 64'(m_cycles));
        chk("trace_count", 64'(trace_count), 64'(m_q.size()));
        chk("trace_wrapped", 64'(trace_wrapped), 64'(m_wrapped));
        chk("trace_rd_valid", 64'(trace_rd_valid), 64'(m_rdv));
        if (m_rdv) chk("trace_rd_data", trace_rd_data, m_rdd);
    endtask

    // One clock: drive inputs, advance the model, then check after the edge.
    task automatic cyc(input bit v, input logic [1:0] op, input int cnt, input bit rd);
        bit exec;
        bit hit;
        cmd_valid   = v;
        cmd_op      = op;
        cmd_count   = cnt[15:0];
        trace_rd_en = rd;
        pc_in       = bpc;
        alu_in      = $urandom;
        exec  = (m_state == 1) || (m_state == 2);
        hit   = 1'b0;
        for (int i = 0; i < 2; i++)
            if (bp_en[i] && (pc_in == bp_addr[i*32 +: 32])) hit = exec;
        m_err = 1'b0;
        m_rdv = 1'b0;
        if (exec) begin
            m_q.push_back({pc_in, alu_in});
            if (m_q.size() > 16) begin
                void'(m_q.pop_front());
                m_wrapped = 1'b1;
            end
            m_cycles = m_cycles + 32'd1;
            if (m_state == 2) m_rem--;
            if (v && op == 2'd0) begin m_state = 3; m_reason = 1; end
            else if (hit) begin m_state = 3; m_reason = 2; end
            else if (m_state == 2 && m_rem == 0) begin m_state = 3; m_reason = 3; end
            if (v && op != 2'd0) m_err = 1'b1;
        end else begin
            if (v && op == 2'd1) m_state = 1;
            if (v && op == 2'd2) begin m_state = 2; m_rem = (cnt == 0) ? 1 : cnt; end
            if (v && op == 2'd3) begin
                m_q.delete();
                m_cycles  = 32'd0;
                m_wrapped = 1'b0;
                m_reason  = 0;
            end
            if (rd && !(v && op == 2'd3) && m_q.size() > 0) begin
                m_rdd = m_q.pop_front();
                m_rdv = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (exec) bpc = bpc + 32'd4;
        check_all();
        cmd_valid   = 1'b0;
        trace_rd_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_count = 16'd0;
        bp_en = 2'b00; bp_addr = 64'd0; pc_in = 32'd0; alu_in = 32'd0;
        trace_rd_en = 1'b0;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;

        // STEP 5 from pc 0: exactly five executed cycles, then readout in order.
        cyc(1'b1, 2'd2, 5, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 2'd0, 0, 1'b0);
        chk("step5_reason", 64'(halt_reason), 64'd3);
        chk("step5_cycles", 64'(cycle_count), 64'd5);
        chk("step5_tcount", 64'(trace_count), 64'd5);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 2'd0, 0, 1'b1);
            chk("step5_pc", 64'(trace_rd_data[63:32]), 64'(4 * i));
        end

        // RUN to a breakpoint at 0x20: nine executed cycles, last pc traced.
        cyc(1'b1, 2'd3, 0, 1'b0);
        bpc = 32'd0; bp_en = 2'b01; bp_addr = {32'h0000_0100, 32'h0000_0020};
        cyc(1'b1, 2'd1, 0, 1'b0);
        for (int i = 0; i < 12; i++) cyc(1'b0, 2'd0, 0, 1'b0);
        chk("bp_reason", 64'(halt_reason), 64'd2);
        chk("bp_cycles", 64'(cycle_count), 64'd9);
        for (int i = 0; i < 9; i++) begin
            cyc(1'b0, 2'd0, 0, 1'b1);
            chk("bp_pc", 64'(trace_rd_data[63:32]), 64'(4 * i));
        end
        bp_en = 2'b00;

        // RUN 20 cycles then HALT: buffer wraps, oldest kept entry is index 4.
        cyc(1'b1, 2'd3, 0, 1'b0);
        bpc = 32'd0;
        cyc(1'b1, 2'd1, 0, 1'b0);
        for (int i = 0; i < 19; i++) cyc(1'b0, 2'd0, 0, 1'b0);
        cyc(1'b1, 2'd0, 0, 1'b0);
        chk("wrap_count", 64'(trace_count), 64'd16);
        chk("wrap_flag", 64'(trace_wrapped), 64'd1);
        chk("wrap_cycles", 64'(cycle_count), 64'd20);
        cyc(1'b0, 2'd0, 0, 1'b1);
        chk("wrap_first_pc", 64'(trace_rd_data[63:32]), 64'd16);

        // HALT coinciding with a breakpoint hit and the final step.
        cyc(1'b1, 2'd3, 0, 1'b0);
        bpc = 32'd0; bp_en = 2'b10; bp_addr = {32'h0000_0008, 32'h0000_0000};
        cyc(1'b1, 2'd2, 3, 1'b0);
        cyc(1'b0, 2'd0, 0, 1'b0);
        cyc(1'b0, 2'd0, 0, 1'b0);
        cyc(1'b1, 2'd0, 0, 1'b0);
        chk("prio_reason", 64'(halt_reason), 64'd1);
        bp_en = 2'b00;

        // RUN while running pulses cmd_err once; STEP 0 executes one cycle.
        cyc(1'b1, 2'd1, 0, 1'b0);
        cyc(1'b1, 2'd1, 0, 1'b0);
        chk("err_pulse", 64'(cmd_err), 64'd1);
        chk("err_state", 64'(run_state), 64'd1);
        cyc(1'b0, 2'd0, 0, 1'b0);
        chk("err_clear", 64'(cmd_err), 64'd0);
        cyc(1'b1, 2'd0, 0, 1'b0);
        cyc(1'b1, 2'd3, 0, 1'b0);
        cyc(1'b1, 2'd2, 0, 1'b0);
        cyc(1'b0, 2'd0, 0, 1'b0);
        cyc(1'b0, 2'd0, 0, 1'b0);
        chk("step0_cycles", 64'(cycle_count), 64'd1);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                bp_en   = 2'($urandom_range(0, 3));
                bp_addr = {bpc + 32'(4 * $urandom_range(0, 8)), bpc + 32'(4 * $urandom_range(0, 8))};
            end
            if ($urandom_range(0, 5) == 0)
                cyc(1'b1, 2'($urandom_range(0, 3)), int'($urandom_range(0, 6)), 1'b0);
            else
                cyc(1'b0, 2'd0, 0, 1'($urandom_range(0, 1)));
        end
        bp_en = 2'b00;

        // Asynchronous reset during RUN drops everything immediately.
        cyc(1'b1, 2'd0, 0, 1'b0);
        cyc(1'b1, 2'd1, 0, 1'b0);
        cyc(1'b0, 2'd0, 0, 1'b0);
        cyc(1'b0, 2'd0, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_core_en", 64'(core_en), 64'd0);
        model_reset();
        check_all();
        #4;
        rst_n = 1'b1;
        cyc(1'b0, 2'd0, 0, 1'b1);
        chk("rst_rd_valid", 64'(trace_rd_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
